// File: rtl/approx_adder_err_sweep.sv
// approx_adder_err_sweep
//
// Error-characterisation stage for a W-bit approximate adder. It drives every
// operand pair (in1, in2) into a combinational adder under test, compares the
// returned sum with the exact sum, and accumulates the sweep-wide error
// metrics: total absolute error, worst-case error with the operands that first
// produced it, and the number of erroneous pairs.
//
// Ports
//   clk         single clock, rising edge
//   rst         asynchronous active-high reset
//   start       begin a sweep (honoured only in IDLE and DONE)
//   in1, in2    operands to the adder under test (straight from the counter)
//   approx_sum  W+1-bit combinational sum from the adder under test
//   busy        high in RUN and DRAIN
//   done        high in DONE; results valid and held
//   err_sum     sum of |approx_sum - exact| over all pairs
//   err_max     largest |approx_sum - exact|
//   wce_in1/2   operands of the first pair reaching err_max
//   err_cnt     number of pairs with nonzero error
module approx_adder_err_sweep #(
  parameter int W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  output logic [W-1:0]     in1,
  output logic [W-1:0]     in2,
  input  logic [W:0]       approx_sum,
  output logic             busy,
  output logic             done,
  output logic [3*W:0]     err_sum,
  output logic [W:0]       err_max,
  output logic [W-1:0]     wce_in1,
  output logic [W-1:0]     wce_in2,
  output logic [2*W:0]     err_cnt
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } state_t;

  state_t          state_reg, state_next;
  logic [2*W-1:0]  cnt_reg;
  logic            clear;
  logic            capture;

  // Capture stage: error and operands of the pair presented last cycle.
  logic            pipe_valid_reg;
  logic [W:0]      pipe_err_reg;
  logic [W-1:0]    pipe_in1_reg;
  logic [W-1:0]    pipe_in2_reg;

  logic [3*W:0]    err_sum_reg;
  logic [W:0]      err_max_reg;
  logic [W-1:0]    wce_in1_reg;
  logic [W-1:0]    wce_in2_reg;
  logic [2*W:0]    err_cnt_reg;

  logic [W:0]      exact;
  logic [W:0]      err;

  // Operands come straight off the counter so the adder path starts at a flop.
  assign in1 = cnt_reg[W-1:0];
  assign in2 = cnt_reg[2*W-1:W];

  assign exact = {1'b0, in1} + {1'b0, in2};
  // Unsigned absolute difference; cannot exceed 2^(W+1)-1.
  assign err   = (approx_sum >= exact) ? (approx_sum - exact) : (exact - approx_sum);

  always_comb begin
    state_next = state_reg;
    clear      = 1'b0;
    capture    = 1'b0;
    case (state_reg)
      IDLE, DONE: begin
        if (start) begin
          clear      = 1'b1;
          state_next = RUN;
        end
      end
      RUN: begin
        capture = 1'b1;
        // Last pair is being captured this edge; counter wraps to zero.
        if (cnt_reg == {(2*W){1'b1}}) begin
          state_next = DRAIN;
        end
      end
      DRAIN: begin
        state_next = DONE;
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg      <= IDLE;
      cnt_reg        <= '0;
      pipe_valid_reg <= 1'b0;
      pipe_err_reg   <= '0;
      pipe_in1_reg   <= '0;
      pipe_in2_reg   <= '0;
      err_sum_reg    <= '0;
      err_max_reg    <= '0;
      wce_in1_reg    <= '0;
      wce_in2_reg    <= '0;
      err_cnt_reg    <= '0;
    end else begin
      state_reg <= state_next;
      if (clear) begin
        cnt_reg        <= '0;
        pipe_valid_reg <= 1'b0;
        err_sum_reg    <= '0;
        err_max_reg    <= '0;
        wce_in1_reg    <= '0;
        wce_in2_reg    <= '0;
        err_cnt_reg    <= '0;
      end else begin
        if (capture) begin
          pipe_err_reg   <= err;
          pipe_in1_reg   <= in1;
          pipe_in2_reg   <= in2;
          pipe_valid_reg <= 1'b1;
          cnt_reg        <= cnt_reg + 1'b1;
        end else begin
          pipe_valid_reg <= 1'b0;
        end

        if (pipe_valid_reg) begin
          err_sum_reg <= err_sum_reg + {{(2*W){1'b0}}, pipe_err_reg};
          err_cnt_reg <= err_cnt_reg + {{(2*W){1'b0}}, (pipe_err_reg != '0)};
          // Strictly greater: on ties the earliest pair is kept.
          if (pipe_err_reg > err_max_reg) begin
            err_max_reg <= pipe_err_reg;
            wce_in1_reg <= pipe_in1_reg;
            wce_in2_reg <= pipe_in2_reg;
          end
        end
      end
    end
  end

  assign busy    = (state_reg == RUN) || (state_reg == DRAIN);
  assign done    = (state_reg == DONE);
  assign err_sum = err_sum_reg;
  assign err_max = err_max_reg;
  assign wce_in1 = wce_in1_reg;
  assign wce_in2 = wce_in2_reg;
  assign err_cnt = err_cnt_reg;

endmodule

// File: tb/tb_approx_adder_err_sweep.sv
// Directed bench for approx_adder_err_sweep at W=4 (256 pairs per sweep).
// The adder under test is modelled in the bench and selected by mode:
//   0 exact adder, 1 sum tied to 0, 2 sum tied to all ones,
//   3 lower-bit-OR adder (bit 0 = a0|b0, upper bits add without carry-in),
//     whose error is a0&b0: 64 pairs of error 1, first at (1,1).
module tb_approx_adder_err_sweep;

  localparam int W = 4;
  localparam int SWEEP_CYCLES = (1 << (2*W)) + 1;

  logic           clk;
  logic           rst;
  logic           start;
  logic [W-1:0]   in1;
  logic [W-1:0]   in2;
  logic [W:0]     approx_sum;
  logic           busy;
  logic           done;
  logic [3*W:0]   err_sum;
  logic [W:0]     err_max;
  logic [W-1:0]   wce_in1;
  logic [W-1:0]   wce_in2;
  logic [2*W:0]   err_cnt;

  int mode;
  int checks;
  int errors;
  int cycles;

  approx_adder_err_sweep #(.W(W)) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .in1        (in1),
    .in2        (in2),
    .approx_sum (approx_sum),
    .busy       (busy),
    .done       (done),
    .err_sum    (err_sum),
    .err_max    (err_max),
    .wce_in1    (wce_in1),
    .wce_in2    (wce_in2),
    .err_cnt    (err_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always_comb begin
    approx_sum = '0;
    case (mode)
      0: approx_sum = {1'b0, in1} + {1'b0, in2};
      1: approx_sum = '0;
      2: approx_sum = '1;
      3: approx_sum = {{1'b0, in1[W-1:1]} + {1'b0, in2[W-1:1]}, in1[0] | in2[0]};
      default: approx_sum = '0;
    endcase
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end else begin
      $display("ok   %s: %0d", tag, obs);
    end
  endtask

  task automatic check_zero_outputs(input string tag);
    check({tag, "_in1"},     64'(in1),     64'd0);
    check({tag, "_in2"},     64'(in2),     64'd0);
    check({tag, "_busy"},    64'(busy),    64'd0);
    check({tag, "_done"},    64'(done),    64'd0);
    check({tag, "_err_sum"}, 64'(err_sum), 64'd0);
    check({tag, "_err_max"}, 64'(err_max), 64'd0);
    check({tag, "_wce_in1"}, 64'(wce_in1), 64'd0);
    check({tag, "_wce_in2"}, 64'(wce_in2), 64'd0);
    check({tag, "_err_cnt"}, 64'(err_cnt), 64'd0);
  endtask

  // Pulses start, checks the cleared state after the start edge, then counts
  // cycles until done (bounded). abort_at > 0 asserts rst after that many
  // cycles of RUN instead. spam pulses start repeatedly while busy.
  task automatic run_sweep(input string tag, input int abort_at, input bit spam, output int n);
    @(negedge clk);
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    check({tag, "_e0_busy"},    64'(busy),    64'd1);
    check({tag, "_e0_done"},    64'(done),    64'd0);
    check({tag, "_e0_err_sum"}, 64'(err_sum), 64'd0);
    check({tag, "_e0_err_max"}, 64'(err_max), 64'd0);
    check({tag, "_e0_err_cnt"}, 64'(err_cnt), 64'd0);
    check({tag, "_e0_cnt"},     64'({in2, in1}), 64'd0);
    n = 0;
    while (n < 1000) begin
      if (abort_at > 0 && n == abort_at) begin
        rst = 1'b1;
        #1;
        check_zero_outputs({tag, "_abort"});
        @(negedge clk);
        rst = 1'b0;
        return;
      end
      start = (spam && n < 250 && (n % 37) == 5) ? 1'b1 : 1'b0;
      @(posedge clk);
      #1;
      n++;
      if (done) break;
    end
    start = 1'b0;
  endtask

  task automatic check_results(input string tag, input int n, input logic [63:0] sum_e,
                               input logic [63:0] max_e, input logic [63:0] w1_e,
                               input logic [63:0] w2_e, input logic [63:0] cnt_e);
    check({tag, "_cycles"},  64'(n),       64'(SWEEP_CYCLES));
    check({tag, "_done"},    64'(done),    64'd1);
    check({tag, "_busy"},    64'(busy),    64'd0);
    check({tag, "_err_sum"}, 64'(err_sum), sum_e);
    check({tag, "_err_max"}, 64'(err_max), max_e);
    check({tag, "_wce_in1"}, 64'(wce_in1), w1_e);
    check({tag, "_wce_in2"}, 64'(wce_in2), w2_e);
    check({tag, "_err_cnt"}, 64'(err_cnt), cnt_e);
  endtask

  initial begin
    checks = 0;
    errors = 0;
    mode   = 0;
    rst    = 1'b1;
    start  = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check_zero_outputs("reset");
    @(negedge clk);
    rst = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("idle_busy", 64'(busy), 64'd0);

    // Exact adder: no error anywhere.
    mode = 0;
    run_sweep("exact", 0, 1'b0, cycles);
    check_results("exact", cycles, 64'd0, 64'd0, 64'd0, 64'd0, 64'd0);

    // Results hold in DONE.
    repeat (5) @(posedge clk);
    #1;
    check("exact_hold_done", 64'(done), 64'd1);

    // Sum tied to 0: err = a+b; sum = 2*16*120, max 30 at (15,15), 255 nonzero.
    mode = 1;
    run_sweep("zero", 0, 1'b0, cycles);
    check_results("zero", cycles, 64'd3840, 64'd30, 64'd15, 64'd15, 64'd255);

    // Start from DONE clears at e0 (checked inside), exact adder again.
    mode = 0;
    run_sweep("rerun", 0, 1'b0, cycles);
    check_results("rerun", cycles, 64'd0, 64'd0, 64'd0, 64'd0, 64'd0);

    // Sum tied to 31: err = 31-(a+b); sum = 256*31-3840, max 31 at (0,0).
    mode = 2;
    run_sweep("ones", 0, 1'b0, cycles);
    check_results("ones", cycles, 64'd4096, 64'd31, 64'd0, 64'd0, 64'd256);

    // Lower-bit-OR adder with start spammed during RUN: ties keep (1,1).
    mode = 3;
    run_sweep("loa_spam", 0, 1'b1, cycles);
    check_results("loa_spam", cycles, 64'd64, 64'd1, 64'd1, 64'd1, 64'd64);

    // Reset mid-sweep, then a clean run must match the uninterrupted one.
    run_sweep("abort", 100, 1'b0, cycles);
    repeat (2) @(posedge clk);
    #1;
    check_zero_outputs("post_abort");
    run_sweep("loa", 0, 1'b0, cycles);
    check_results("loa", cycles, 64'd64, 64'd1, 64'd1, 64'd1, 64'd64);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
